generic_1clk_fifo_ctrl: RTL and testbench

- Single-clock FIFO for same-domain buffering; used where no clock crossing exists.
- Parametrised in data width and depth; depth need not be a power of two.
- Adds capabilities beyond earlier FIFO envelopes: programmable almost-full/almost-empty flags, synchronous flush, a selectable first-word-fall-through (FWFT) read mode, and sticky error flags with explicit clear.
- Storage is an internal register array, so no compiled memory or test ports are needed.

---
 rtl/generic_1clk_fifo_ctrl.sv | 163 ++++++++++++++++
 tb/tb_generic_1clk_fifo_ctrl.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/generic_1clk_fifo_ctrl.sv
// Single-clock FIFO controller with register-array storage, programmable almost flags,
// synchronous flush, optional first-word-fall-through read and sticky error flags.
module generic_1clk_fifo_ctrl #(
    parameter int unsigned DAT_WIDTH      = 32,
    parameter int unsigned NUM_OF_ENTRIES = 24,
    parameter int unsigned PTR_WIDTH      = 5,
    parameter int unsigned AFULL_THR      = 20,
    parameter int unsigned AEMPTY_THR     = 4,
    parameter int unsigned FWFT           = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    input  logic                 wr_op,
    input  logic [DAT_WIDTH-1:0] wr_data,
    input  logic                 rd_op,
    output logic [DAT_WIDTH-1:0] rd_data,
    output logic                 rd_valid,
    output logic                 full,
    output logic                 empty,
    output logic                 almost_full,
    output logic                 almost_empty,
    output logic [PTR_WIDTH:0]   entry_used,
    input  logic                 err_clr,
    output logic                 err_wrfull,
    output logic                 err_rdempty
);

    localparam int unsigned CNT_WIDTH = PTR_WIDTH + 1;

    localparam logic [PTR_WIDTH-1:0] LAST_PTR   = PTR_WIDTH'(NUM_OF_ENTRIES - 1);
    localparam logic [CNT_WIDTH-1:0] DEPTH_CNT  = CNT_WIDTH'(NUM_OF_ENTRIES);
    localparam logic [CNT_WIDTH-1:0] AFULL_CNT  = CNT_WIDTH'(AFULL_THR);
    localparam logic [CNT_WIDTH-1:0] AEMPTY_CNT = CNT_WIDTH'(AEMPTY_THR);
    localparam logic [CNT_WIDTH-1:0] ONE_CNT    = CNT_WIDTH'(1);

    logic [DAT_WIDTH-1:0] mem_q [NUM_OF_ENTRIES];

    logic [PTR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

    logic full_q, full_d;
    logic empty_q, empty_d;
    logic afull_q, afull_d;
    logic aempty_q, aempty_d;
    logic err_wrfull_q, err_wrfull_d;
    logic err_rdempty_q, err_rdempty_d;

    logic wr_acc;
    logic rd_acc;

    // Pointers wrap at the configured depth, which need not be a power of two.
    function automatic logic [PTR_WIDTH-1:0] ptr_inc(input logic [PTR_WIDTH-1:0] ptr);
        if (ptr == LAST_PTR) begin
            return '0;
        end
        return ptr + PTR_WIDTH'(1);
    endfunction

    always_comb begin
        wr_acc = wr_op & ~full_q & ~flush;
        rd_acc = rd_op & ~empty_q & ~flush;

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (wr_acc) begin
                wr_ptr_d = ptr_inc(wr_ptr_q);
            end
            if (rd_acc) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            unique case ({wr_acc, rd_acc})
                2'b10:   cnt_d = cnt_q + ONE_CNT;
                2'b01:   cnt_d = cnt_q - ONE_CNT;
                default: cnt_d = cnt_q;
            endcase
        end

        // Flags are computed from the next count so they track entry_used with no lag.
        full_d   = (cnt_d == DEPTH_CNT);
        empty_d  = (cnt_d == '0);
        afull_d  = (cnt_d >= AFULL_CNT);
        aempty_d = (cnt_d <= AEMPTY_CNT);

        // A new error event wins over a simultaneous clear; flush masks the attempt.
        err_wrfull_d  = (wr_op & full_q & ~flush) | (err_wrfull_q & ~err_clr);
        err_rdempty_d = (rd_op & empty_q & ~flush) | (err_rdempty_q & ~err_clr);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            cnt_q         <= '0;
            full_q        <= 1'b0;
            empty_q       <= 1'b1;
            afull_q       <= (AFULL_CNT == '0);
            aempty_q      <= 1'b1;
            err_wrfull_q  <= 1'b0;
            err_rdempty_q <= 1'b0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            cnt_q         <= cnt_d;
            full_q        <= full_d;
            empty_q       <= empty_d;
            afull_q       <= afull_d;
            aempty_q      <= aempty_d;
            err_wrfull_q  <= err_wrfull_d;
            err_rdempty_q <= err_rdempty_d;
        end
    end

    // Storage is intentionally not reset.
    always_ff @(posedge clk) begin
        if (!reset && wr_acc) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    generate
        if (FWFT == 0) begin : g_reg_read
            logic [DAT_WIDTH-1:0] rd_data_q;
            logic                 rd_valid_q;

            always_ff @(posedge clk) begin
                if (reset) begin
                    rd_data_q  <= '0;
                    rd_valid_q <= 1'b0;
                end else begin
                    rd_valid_q <= rd_acc;
                    if (rd_acc) begin
                        rd_data_q <= mem_q[rd_ptr_q];
                    end
                end
            end

            assign rd_data  = rd_data_q;
            assign rd_valid = rd_valid_q;
        end else begin : g_fwft_read
            // Head entry is shown directly; zero while empty so reset shows a clean bus.
            assign rd_data  = empty_q ? '0 : mem_q[rd_ptr_q];
            assign rd_valid = ~empty_q;
        end
    endgenerate

    assign full         = full_q;
    assign empty        = empty_q;
    assign almost_full  = afull_q;
    assign almost_empty = aempty_q;
    assign entry_used   = cnt_q;
    assign err_wrfull   = err_wrfull_q;
    assign err_rdempty  = err_rdempty_q;

endmodule

// File: tb/tb_generic_1clk_fifo_ctrl.sv
// Bench for generic_1clk_fifo_ctrl: registered-read instance checked through a read-data
// scoreboard plus per-cycle flag checks, and a FWFT instance checked with directed vectors.
module tb_generic_1clk_fifo_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic        wr_op = 1'b0;
    logic [31:0] wr_data = '0;
    logic        rd_op = 1'b0;
    logic        err_clr = 1'b0;
    logic [31:0] rd_data;
    logic        rd_valid, full, empty, almost_full, almost_empty;
    logic [5:0]  entry_used;
    logic        err_wrfull, err_rdempty;

    logic        flush_f = 1'b0;
    logic        wr_op_f = 1'b0;
    logic [31:0] wr_data_f = '0;
    logic        rd_op_f = 1'b0;
    logic        err_clr_f = 1'b0;
    logic [31:0] rd_data_f;
    logic        rd_valid_f, full_f, empty_f, almost_full_f, almost_empty_f;
    logic [5:0]  entry_used_f;
    logic        err_wrfull_f, err_rdempty_f;

    generic_1clk_fifo_ctrl #(.FWFT(0)) u_reg (
        .clk(clk), .reset(reset), .flush(flush), .wr_op(wr_op), .wr_data(wr_data),
        .rd_op(rd_op), .rd_data(rd_data), .rd_valid(rd_valid), .full(full), .empty(empty),
        .almost_full(almost_full), .almost_empty(almost_empty), .entry_used(entry_used),
        .err_clr(err_clr), .err_wrfull(err_wrfull), .err_rdempty(err_rdempty)
    );

    generic_1clk_fifo_ctrl #(.FWFT(1)) u_fwft (
        .clk(clk), .reset(reset), .flush(flush_f), .wr_op(wr_op_f), .wr_data(wr_data_f),
        .rd_op(rd_op_f), .rd_data(rd_data_f), .rd_valid(rd_valid_f), .full(full_f),
        .empty(empty_f), .almost_full(almost_full_f), .almost_empty(almost_empty_f),
        .entry_used(entry_used_f), .err_clr(err_clr_f), .err_wrfull(err_wrfull_f),
        .err_rdempty(err_rdempty_f)
    );

    int errors = 0;
    int checks = 0;

    logic [31:0] model_q[$];
    logic [31:0] exp_q[$];
    logic        m_ewf = 1'b0;
    logic        m_erd = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    // Scoreboard monitor for the registered-read instance.
    logic [31:0] mon_exp;
    always @(negedge clk) begin
        if (!reset && rd_valid === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL monitor: rd_valid with data 0x%0h, required no read", rd_data);
            end else begin
                mon_exp = exp_q.pop_front();
                if (rd_data !== mon_exp) begin
                    errors++;
                    $display("FAIL monitor rd_data: got 0x%0h, required 0x%0h", rd_data, mon_exp);
                end
            end
        end
    end

    // One cycle of stimulus on the registered-read instance, followed by flag checks.
    task automatic op(input logic w, input logic [31:0] d, input logic r, input logic f,
                      input logic c, input string tag);
        int   n;
        logic wacc, racc, isfull, isempty;
        n       = model_q.size();
        isfull  = (n == 24);
        isempty = (n == 0);
        wacc    = w && !f && !isfull;
        racc    = r && !f && !isempty;
        m_ewf   = (w && !f && isfull) ? 1'b1 : (c ? 1'b0 : m_ewf);
        m_erd   = (r && !f && isempty) ? 1'b1 : (c ? 1'b0 : m_erd);
        if (racc) exp_q.push_back(model_q.pop_front());
        if (wacc) model_q.push_back(d);
        if (f) model_q.delete();
        wr_op = w; wr_data = d; rd_op = r; flush = f; err_clr = c;
        @(posedge clk);
        #1;
        wr_op = 1'b0; rd_op = 1'b0; flush = 1'b0; err_clr = 1'b0;
        n = model_q.size();
        chk($sformatf("%s entry_used", tag), 32'(entry_used), n);
        chk($sformatf("%s full", tag), 32'(full), 32'(n == 24));
        chk($sformatf("%s empty", tag), 32'(empty), 32'(n == 0));
        chk($sformatf("%s almost_full", tag), 32'(almost_full), 32'(n >= 20));
        chk($sformatf("%s almost_empty", tag), 32'(almost_empty), 32'(n <= 4));
        chk($sformatf("%s err_wrfull", tag), 32'(err_wrfull), 32'(m_ewf));
        chk($sformatf("%s err_rdempty", tag), 32'(err_rdempty), 32'(m_erd));
        chk($sformatf("%s rd_valid", tag), 32'(rd_valid), 32'(racc));
    endtask

    task automatic wr(input logic [31:0] d);
        op(1'b1, d, 1'b0, 1'b0, 1'b0, "wr");
    endtask

    task automatic rd();
        op(1'b0, '0, 1'b1, 1'b0, 1'b0, "rd");
    endtask

    task automatic op_f(input logic w, input logic [31:0] d, input logic r);
        wr_op_f = w; wr_data_f = d; rd_op_f = r;
        @(posedge clk);
        #1;
        wr_op_f = 1'b0; rd_op_f = 1'b0;
    endtask

    task automatic chk_reset(input string tag);
        chk($sformatf("%s entry_used", tag), 32'(entry_used), 0);
        chk($sformatf("%s empty", tag), 32'(empty), 1);
        chk($sformatf("%s full", tag), 32'(full), 0);
        chk($sformatf("%s almost_empty", tag), 32'(almost_empty), 1);
        chk($sformatf("%s almost_full", tag), 32'(almost_full), 0);
        chk($sformatf("%s rd_valid", tag), 32'(rd_valid), 0);
        chk($sformatf("%s rd_data", tag), rd_data, 0);
        chk($sformatf("%s err_wrfull", tag), 32'(err_wrfull), 0);
        chk($sformatf("%s err_rdempty", tag), 32'(err_rdempty), 0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk_reset("reset");
        chk("reset fwft rd_valid", 32'(rd_valid_f), 0);
        chk("reset fwft empty", 32'(empty_f), 1);
        chk("reset fwft rd_data", rd_data_f, 0);
        reset = 1'b0;

        // Fill to full, then overflow attempt.
        for (int i = 0; i < 24; i++) wr(32'(i));
        chk("fill full", 32'(full), 1);
        chk("fill entry_used", 32'(entry_used), 24);
        op(1'b1, 32'hDEAD, 1'b0, 1'b0, 1'b0, "overflow");
        chk("overflow err_wrfull", 32'(err_wrfull), 1);

        // Simultaneous read/write while full: only the read is taken.
        op(1'b1, 32'h99, 1'b1, 1'b0, 1'b0, "rdwr_full");
        chk("rdwr_full entry_used", 32'(entry_used), 23);
        op(1'b0, '0, 1'b0, 1'b0, 1'b1, "clr");

        while (model_q.size() > 5) rd();
        op(1'b1, 32'h55, 1'b1, 1'b0, 1'b0, "rdwr_5");
        chk("rdwr_5 entry_used", 32'(entry_used), 5);
        while (model_q.size() > 0) rd();

        // Registered read latency and underflow.
        wr(32'hA5A5_0001);
        rd();
        chk("reg_read rd_valid", 32'(rd_valid), 1);
        chk("reg_read rd_data", rd_data, 32'hA5A5_0001);
        rd();
        chk("underflow err_rdempty", 32'(err_rdempty), 1);
        chk("underflow rd_valid", 32'(rd_valid), 0);
        op(1'b0, '0, 1'b0, 1'b0, 1'b1, "clr2");

        // Interleaved traffic holding 3..10 entries; pointers wrap twice.
        for (int i = 0; i < 3; i++) wr(32'h0F00 + 32'(i));
        for (int i = 0; i < 50; i++) begin
            if ((i % 4 == 0) && model_q.size() < 10)
                op(1'b1, 32'h1000 + 32'(i), 1'b0, 1'b0, 1'b0, "wrap_w");
            else
                op(1'b1, 32'h1000 + 32'(i), 1'b1, 1'b0, 1'b0, "wrap_wr");
        end
        while (model_q.size() > 0) rd();

        // Flush with sticky errors pending.
        rd();
        for (int i = 0; i < 12; i++) wr(32'h2000 + 32'(i));
        op(1'b1, 32'hBAD0, 1'b0, 1'b1, 1'b0, "flush12");
        chk("flush12 entry_used", 32'(entry_used), 0);
        chk("flush12 err_rdempty kept", 32'(err_rdempty), 1);
        for (int i = 0; i < 24; i++) wr(32'h3000 + 32'(i));
        wr(32'hEE);
        op(1'b1, 32'hBAD1, 1'b1, 1'b1, 1'b0, "flush_full");
        chk("flush_full rd_valid", 32'(rd_valid), 0);
        op(1'b0, '0, 1'b0, 1'b0, 1'b1, "clr3");
        chk("clr3 err_wrfull", 32'(err_wrfull), 0);
        chk("clr3 err_rdempty", 32'(err_rdempty), 0);
        op(1'b0, '0, 1'b1, 1'b0, 1'b1, "set_wins");
        chk("set_wins err_rdempty", 32'(err_rdempty), 1);
        op(1'b0, '0, 1'b0, 1'b0, 1'b1, "clr4");

        // Reset in the middle of traffic.
        for (int i = 0; i < 3; i++) wr(32'h4000 + 32'(i));
        reset = 1'b1; wr_op = 1'b1; rd_op = 1'b1; wr_data = 32'h4444;
        @(posedge clk);
        #1;
        wr_op = 1'b0; rd_op = 1'b0;
        model_q.delete();
        m_ewf = 1'b0;
        m_erd = 1'b0;
        chk("midreset entry_used", 32'(entry_used), 0);
        chk("midreset empty", 32'(empty), 1);
        chk("midreset rd_valid", 32'(rd_valid), 0);
        reset = 1'b0;
        wr(32'h77);
        rd();

        // First-word-fall-through instance.
        wr_op_f = 1'b1; wr_data_f = 32'h11;
        #1;
        chk("fwft pre-write rd_valid", 32'(rd_valid_f), 0);
        op_f(1'b1, 32'h11, 1'b0);
        chk("fwft first rd_valid", 32'(rd_valid_f), 1);
        chk("fwft first rd_data", rd_data_f, 32'h11);
        op_f(1'b1, 32'h22, 1'b0);
        chk("fwft head held", rd_data_f, 32'h11);
        chk("fwft entry_used", 32'(entry_used_f), 2);
        op_f(1'b0, '0, 1'b1);
        chk("fwft pop rd_data", rd_data_f, 32'h22);
        chk("fwft pop rd_valid", 32'(rd_valid_f), 1);
        op_f(1'b0, '0, 1'b1);
        chk("fwft drained empty", 32'(empty_f), 1);
        chk("fwft drained rd_valid", 32'(rd_valid_f), 0);

        repeat (2) @(posedge clk);
        #1;
        chk("scoreboard drained", 32'(exp_q.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
